// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the host-side CNN pixel-stream transmitter.
//   - stream_state_t : transmitter FSM states
//   - CNN_* defaults : frame geometry, pixel/result widths, result timeout
//   - FRAME_PIXELS / ADDR_W : derived frame size and raster address width
//   - sat_inc32      : saturating 32-bit increment used by the latency counter
package cnn_stream_pkg;

    localparam int CNN_IMG_WIDTH      = 32;
    localparam int CNN_IMG_HEIGHT     = 32;
    localparam int CNN_PIXEL_W        = 8;
    localparam int CNN_RESULT_W       = 48;
    localparam int CNN_TIMEOUT_CYCLES = 65536;

    localparam int FRAME_PIXELS = CNN_IMG_WIDTH * CNN_IMG_HEIGHT;
    localparam int ADDR_W       = $clog2(FRAME_PIXELS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_STREAM,
        ST_WAIT_RESULT
    } stream_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Single-clock frame buffer: one write port, one registered read port.
// Written as a plain array with a registered read and no reset so synthesis
// maps it onto block RAM.
//   clk   in  clock
//   we    in  write strobe
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address (sampled every cycle)
//   rdata out registered read data, valid the cycle after raddr
module frame_buffer_ram
    import cnn_stream_pkg::*;
#(
    parameter int DEPTH  = FRAME_PIXELS,
    parameter int DATA_W = CNN_PIXEL_W,
    parameter int AW     = ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pixel_frame_streamer.sv
// Host-side transmitter for the CNN pixel-stream interface. Holds one frame,
// streams it on launch (start pulse, one gap cycle, N contiguous pixels),
// then waits for the CNN result and reports it with the start-to-result
// latency.
//   clk, rst             clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data frame buffer write port (accepted only while idle)
//   launch               stream request (sampled only while idle)
//   start_signal         one-cycle frame-start pulse to the CNN
//   pixel_valid/pixel_in pixel stream to the CNN
//   final_result_valid/final_lane_result  result from the CNN
//   busy                 high whenever not idle
//   done                 one-cycle completion pulse
//   result_q             captured result
//   latency_cycles       cycles from the start_signal cycle to the done cycle
//   err_timeout          sticky: no result within TIMEOUT_CYCLES
//   err_early            sticky: result arrived before the last pixel
module pixel_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int IMG_WIDTH      = CNN_IMG_WIDTH,
    parameter int IMG_HEIGHT     = CNN_IMG_HEIGHT,
    parameter int PIXEL_W        = CNN_PIXEL_W,
    parameter int RESULT_W       = CNN_RESULT_W,
    parameter int TIMEOUT_CYCLES = CNN_TIMEOUT_CYCLES
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_en,
    input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr,
    input  logic [PIXEL_W-1:0]                      wr_data,
    input  logic                                    launch,
    output logic                                    start_signal,
    output logic                                    pixel_valid,
    output logic [PIXEL_W-1:0]                      pixel_in,
    input  logic                                    final_result_valid,
    input  logic signed [RESULT_W-1:0]              final_lane_result,
    output logic                                    busy,
    output logic                                    done,
    output logic signed [RESULT_W-1:0]              result_q,
    output logic [31:0]                             latency_cycles,
    output logic                                    err_timeout,
    output logic                                    err_early
);

    localparam int FRAME_N = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW      = $clog2(FRAME_N);
    localparam int WCW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0]  LAST_ADDR = AW'(FRAME_N - 1);
    localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT_CYCLES - 1);

    stream_state_t              state_reg, state_next;
    logic [AW-1:0]              addr_reg, addr_next;
    logic [WCW-1:0]             wait_reg, wait_next;
    logic [31:0]                latency_reg, latency_next;
    logic                       frozen_reg, frozen_next;
    logic signed [RESULT_W-1:0] result_reg, result_next;
    logic                       err_timeout_reg, err_timeout_next;
    logic                       err_early_reg, err_early_next;
    logic                       start_reg, start_next;
    logic                       valid_reg, valid_next;
    logic                       busy_reg, busy_next;
    logic                       done_reg, done_next;

    logic                       ram_we;
    logic [PIXEL_W-1:0]         ram_q;
    logic                       pre_result_phase;

    assign ram_we = wr_en && (state_reg == ST_IDLE);

    // The read address is the stream counter itself: it sits at 0 through
    // START/GAP so the GAP-cycle read delivers pixel 0 at STREAM entry, and
    // during STREAM it runs one ahead of the pixel being presented.
    frame_buffer_ram #(
        .DEPTH  (FRAME_N),
        .DATA_W (PIXEL_W),
        .AW     (AW)
    ) u_frame_buffer (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (addr_reg),
        .rdata (ram_q)
    );

    assign pre_result_phase = (state_reg == ST_START) || (state_reg == ST_GAP) ||
                              (state_reg == ST_STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wait_reg        <= '0;
            latency_reg     <= '0;
            frozen_reg      <= 1'b0;
            result_reg      <= '0;
            err_timeout_reg <= 1'b0;
            err_early_reg   <= 1'b0;
            start_reg       <= 1'b0;
            valid_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wait_reg        <= wait_next;
            latency_reg     <= latency_next;
            frozen_reg      <= frozen_next;
            result_reg      <= result_next;
            err_timeout_reg <= err_timeout_next;
            err_early_reg   <= err_early_next;
            start_reg       <= start_next;
            valid_reg       <= valid_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wait_next        = wait_reg;
        latency_next     = latency_reg;
        frozen_next      = frozen_reg;
        result_next      = result_reg;
        err_timeout_next = err_timeout_reg;
        err_early_next   = err_early_reg;
        done_next        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (launch) begin
                    state_next       = ST_START;
                    addr_next        = '0;
                    latency_next     = '0;
                    frozen_next      = 1'b0;
                    err_timeout_next = 1'b0;
                    err_early_next   = 1'b0;
                end
            end
            ST_START: begin
                state_next = ST_GAP;
            end
            ST_GAP: begin
                state_next = ST_STREAM;
                addr_next  = addr_reg + AW'(1);
            end
            ST_STREAM: begin
                addr_next = (addr_reg == LAST_ADDR) ? '0 : addr_reg + AW'(1);
                // Counter back at 0 means the last pixel is on the bus now.
                if (addr_reg == '0) begin
                    if (err_early_reg || final_result_valid) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_WAIT_RESULT;
                        wait_next  = '0;
                    end
                end
            end
            ST_WAIT_RESULT: begin
                if (final_result_valid) begin
                    result_next = final_lane_result;
                    done_next   = 1'b1;
                    state_next  = ST_IDLE;
                end else if (wait_reg == LAST_WAIT) begin
                    err_timeout_next = 1'b1;
                    done_next        = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    wait_next = wait_reg + WCW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A result before the frame is fully sent is flagged and the first
        // one is kept; streaming carries on regardless.
        if (pre_result_phase && final_result_valid) begin
            err_early_next = 1'b1;
            if (!frozen_reg) begin
                result_next = final_lane_result;
            end
        end

        // Latency counts every active cycle up to and including the cycle the
        // result is sampled, so the value seen alongside done equals the
        // distance from the start_signal cycle to the done cycle.
        if (state_reg != ST_IDLE && !frozen_reg) begin
            latency_next = sat_inc32(latency_reg);
            if (final_result_valid) begin
                frozen_next = 1'b1;
            end
        end

        start_next = (state_next == ST_START);
        valid_next = (state_next == ST_STREAM);
        busy_next  = (state_next != ST_IDLE);
    end

    assign start_signal   = start_reg;
    assign pixel_valid    = valid_reg;
    // RAM output register gated by the registered qualifier: pixel_in is
    // zero outside STREAM and drops together with pixel_valid on reset.
    assign pixel_in       = ram_q & {PIXEL_W{valid_reg}};
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign result_q       = result_reg;
    assign latency_cycles = latency_reg;
    assign err_timeout    = err_timeout_reg;
    assign err_early      = err_early_reg;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
module tb_pixel_frame_streamer;

    localparam int W   = 32;
    localparam int H   = 32;
    localparam int N   = W * H;
    localparam int PW  = 8;
    localparam int RW  = 48;
    localparam int TMO = 256;
    localparam int AW  = $clog2(N);

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_EARLY   = 1;
    localparam int MODE_TIMEOUT = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [PW-1:0]        wr_data;
    logic                 launch;
    logic                 start_signal;
    logic                 pixel_valid;
    logic [PW-1:0]        pixel_in;
    logic                 final_result_valid;
    logic signed [RW-1:0] final_lane_result;
    logic                 busy;
    logic                 done;
    logic signed [RW-1:0] result_q;
    logic [31:0]          latency_cycles;
    logic                 err_timeout;
    logic                 err_early;

    pixel_frame_streamer #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .PIXEL_W        (PW),
        .RESULT_W       (RW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .launch             (launch),
        .start_signal       (start_signal),
        .pixel_valid        (pixel_valid),
        .pixel_in           (pixel_in),
        .final_result_valid (final_result_valid),
        .final_lane_result  (final_lane_result),
        .busy               (busy),
        .done               (done),
        .result_q           (result_q),
        .latency_cycles     (latency_cycles),
        .err_timeout        (err_timeout),
        .err_early          (err_early)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_no = 0;

    // Reference model: buffer contents and last captured result.
    logic [PW-1:0]        model_mem [N];
    logic signed [RW-1:0] exp_result;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (frame %0d)", tag, obs, exp, frame_no);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [RW-1:0] rand_res();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[RW-1:0];
    endfunction

    task automatic write_px(input int addr, input logic [PW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        model_mem[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    // One launched frame. Cycle index 0 is the start_signal cycle, 1 the gap,
    // k+2 pixel k. mode/param: NORMAL -> result d=param cycles after the last
    // pixel; EARLY -> result during pixel param; TIMEOUT -> no result.
    // inj_at: pixel at which a launch + write of 0xAB to addr 0 is attempted.
    // rst_at: pixel at which reset is asserted (frame abandoned).
    task automatic run_frame(input int mode, input int param, input int inj_at,
                             input bit co_wr, input logic [PW-1:0] co_data,
                             input int rst_at, input logic signed [RW-1:0] res);
        int resp_idx;
        int done_idx;
        resp_idx = -1;
        frame_no++;

        launch = 1'b1;
        if (co_wr) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = co_data;
            model_mem[0] = co_data;
        end
        tick();
        launch = 1'b0;
        wr_en  = 1'b0;
        check_eq("start_hi", {start_signal, pixel_valid, busy, done}, 4'b1010);
        check_eq("lat_clr", latency_cycles, 0);
        check_eq("err_clr", {err_timeout, err_early}, 2'b00);

        tick();
        check_eq("gap_quiet", {start_signal, pixel_valid, pixel_in}, 0);

        for (int k = 0; k < N; k++) begin
            tick();
            final_result_valid = 1'b0;
            wr_en  = 1'b0;
            launch = 1'b0;
            check_eq("pix", {start_signal, pixel_valid, pixel_in}, {1'b0, 1'b1, model_mem[k]});
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_eq("rst_quiet", {start_signal, pixel_valid, busy, done, pixel_in}, 0);
                tick();
                check_eq("rst_hold", {busy, result_q}, 0);
                exp_result = '0;
                rst = 1'b0;
                tick();
                check_eq("rst_idle", {busy, start_signal, pixel_valid}, 3'b000);
                $display("frame %0d: reset at pixel %0d", frame_no, k);
                return;
            end
            if (mode == MODE_EARLY && k == param) begin
                final_result_valid = 1'b1;
                final_lane_result  = res;
                resp_idx = k + 2;
            end
            if (k == inj_at) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 8'hAB;
                launch  = 1'b1;
            end
        end

        if (mode == MODE_NORMAL) resp_idx = N + 1 + param;
        if (mode == MODE_NORMAL)     done_idx = resp_idx + 1;
        else if (mode == MODE_EARLY) done_idx = N + 2;
        else                         done_idx = N + 2 + TMO;

        for (int c = N + 2; c <= done_idx; c++) begin
            tick();
            final_result_valid = 1'b0;
            wr_en  = 1'b0;
            launch = 1'b0;
            if (c == N + 2) check_eq("pv_fall", pixel_valid, 1'b0);
            check_eq("done_at", done, (c == done_idx));
            if (mode == MODE_NORMAL && c == resp_idx) begin
                final_result_valid = 1'b1;
                final_lane_result  = res;
            end
        end

        check_eq("busy_done", busy, 1'b0);
        if (mode != MODE_TIMEOUT) begin
            exp_result = res;
            check_eq("latency", latency_cycles, resp_idx + 1);
        end
        check_eq("result", result_q, exp_result);
        check_eq("err_flags", {err_timeout, err_early},
                 (mode == MODE_TIMEOUT) ? 2'b10 : (mode == MODE_EARLY) ? 2'b01 : 2'b00);

        tick();
        check_eq("done_1cyc", done, 1'b0);
        $display("frame %0d: mode %0d param %0d result %0d latency %0d",
                 frame_no, mode, param, result_q, latency_cycles);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        int param;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        launch = 1'b0;
        final_result_valid = 1'b0;
        final_lane_result = '0;
        exp_result = '0;

        repeat (3) tick();
        check_eq("reset_ctl", {start_signal, pixel_valid, busy, done, err_timeout, err_early}, 0);
        check_eq("reset_pix", pixel_in, 0);
        check_eq("reset_res", result_q, 0);
        check_eq("reset_lat", latency_cycles, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) write_px(i, i[PW-1:0]);

        run_frame(MODE_NORMAL, 200, -1, 1'b0, 8'h00, -1, -48'sd5);
        run_frame(MODE_TIMEOUT, 0, -1, 1'b0, 8'h00, -1, '0);
        run_frame(MODE_EARLY, 500, -1, 1'b0, 8'h00, -1, rand_res());
        run_frame(MODE_NORMAL, $urandom_range(1, TMO - 1), 100, 1'b0, 8'h00, -1, rand_res());
        run_frame(MODE_NORMAL, $urandom_range(1, TMO - 1), -1, 1'b0, 8'h00, -1, rand_res());
        run_frame(MODE_NORMAL, 1, -1, 1'b1, 8'h5A, -1, rand_res());
        run_frame(MODE_NORMAL, 10, -1, 1'b0, 8'h00, 300, rand_res());

        for (int i = 0; i < N; i++) write_px(i, PW'($urandom()));
        run_frame(MODE_NORMAL, $urandom_range(1, TMO - 1), -1, 1'b0, 8'h00, -1, rand_res());

        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 32; j++) write_px($urandom_range(0, N - 1), PW'($urandom()));
            mode = $urandom_range(0, 2);
            if (mode == MODE_NORMAL)     param = $urandom_range(1, TMO - 1);
            else if (mode == MODE_EARLY) param = $urandom_range(0, N - 1);
            else                         param = 0;
            run_frame(mode, param, $urandom_range(0, N - 2), $urandom_range(0, 1) == 1,
                      PW'($urandom()), -1, rand_res());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
